// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: controller state encoding and datapath widths.
package pipe_ctrl_pkg;

    localparam int REG_W   = 3;
    localparam int PC_W    = 12;
    localparam int INSTR_W = 19;

    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        S_RUN,
        S_LU_STALL,
        S_BR_FLUSH,
        S_MEM_WAIT
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources of the IF/ID instruction.
module load_use_detect #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
    input  logic             idExMemRead,
    input  logic [REG_W-1:0] idExRd,
    input  logic [REG_W-1:0] ifIdRs1,
    input  logic [REG_W-1:0] ifIdRs2,
    input  logic             ifIdUsesRs2,
    output logic             hazard
);

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = idExMemRead && (idExRd != '0) &&
                    ((idExRd == ifIdRs1) || (ifIdUsesRs2 && (idExRd == ifIdRs2)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and instruction-fetch waits.
module hazard_ctrl #(
    parameter int LU_STALL   = 1,
    parameter int BR_PENALTY = 1,
    parameter int REG_W      = pipe_ctrl_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idExMemRead,
    input  logic [REG_W-1:0] idExRd,
    input  logic [REG_W-1:0] ifIdRs1,
    input  logic [REG_W-1:0] ifIdRs2,
    input  logic             ifIdUsesRs2,
    input  logic             branchTaken,
    input  logic             imemReady,
    output logic             pcWriteEn,
    output logic             ifIdWriteEn,
    output logic             ifIdFlush,
    output logic             idExBubble,
    output logic [15:0]      stallCount
);
    import pipe_ctrl_pkg::*;

    localparam logic [3:0] LU_INIT = 4'(LU_STALL - 1);
    localparam logic [3:0] BR_INIT = 4'(BR_PENALTY - 1);

    state_t     state;
    state_t     nextState;
    logic [3:0] cnt;
    logic [3:0] nextCnt;
    logic       hazard;

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .idExMemRead (idExMemRead),
        .idExRd      (idExRd),
        .ifIdRs1     (ifIdRs1),
        .ifIdRs2     (ifIdRs2),
        .ifIdUsesRs2 (ifIdUsesRs2),
        .hazard      (hazard)
    );

    // A taken branch wins in every state and reloads the counter; otherwise each state decides.
    always_comb begin
        nextState   = state;
        nextCnt     = cnt;
        pcWriteEn   = 1'b1;
        ifIdWriteEn = 1'b1;
        ifIdFlush   = 1'b0;
        idExBubble  = 1'b0;
        if (branchTaken) begin
            pcWriteEn   = 1'b1;
            ifIdWriteEn = 1'b0;
            ifIdFlush   = 1'b1;
            idExBubble  = 1'b1;
            if (BR_PENALTY > 1) begin
                nextState = S_BR_FLUSH;
                nextCnt   = BR_INIT;
            end else begin
                nextState = S_RUN;
                nextCnt   = 4'd0;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (hazard) begin
                        pcWriteEn   = 1'b0;
                        ifIdWriteEn = 1'b0;
                        idExBubble  = 1'b1;
                        if (LU_STALL > 1) begin
                            nextState = S_LU_STALL;
                            nextCnt   = LU_INIT;
                        end
                    end else if (!imemReady) begin
                        pcWriteEn   = 1'b0;
                        ifIdWriteEn = 1'b0;
                        ifIdFlush   = 1'b1;
                        nextState   = S_MEM_WAIT;
                    end
                end
                S_LU_STALL: begin
                    pcWriteEn   = 1'b0;
                    ifIdWriteEn = 1'b0;
                    idExBubble  = 1'b1;
                    nextCnt     = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        nextState = S_RUN;
                        nextCnt   = 4'd0;
                    end
                end
                S_BR_FLUSH: begin
                    pcWriteEn   = imemReady;
                    ifIdWriteEn = 1'b0;
                    ifIdFlush   = 1'b1;
                    nextCnt     = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        nextState = S_RUN;
                        nextCnt   = 4'd0;
                    end
                end
                S_MEM_WAIT: begin
                    if (imemReady) begin
                        nextState = S_RUN;
                    end else begin
                        pcWriteEn   = 1'b0;
                        ifIdWriteEn = 1'b0;
                        ifIdFlush   = 1'b1;
                    end
                end
                default: nextState = S_RUN;
            endcase
        end
        if (rst) begin
            pcWriteEn   = 1'b0;
            ifIdWriteEn = 1'b0;
            ifIdFlush   = 1'b1;
            idExBubble  = 1'b1;
        end
    end

    // Stall counter saturates rather than wrapping so long waits stay visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            cnt        <= 4'd0;
            stallCount <= 16'd0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (!pcWriteEn && (stallCount != 16'hFFFF)) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl using two parameterisations driven from shared inputs.
module tb_hazard_ctrl;

    localparam logic [3:0] PASS  = 4'b1100;
    localparam logic [3:0] STALL = 4'b0001;
    localparam logic [3:0] BRNCH = 4'b1011;
    localparam logic [3:0] FWAIT = 4'b0010;
    localparam logic [3:0] BRFL  = 4'b1010;
    localparam logic [3:0] RSTO  = 4'b0011;

    typedef struct packed {
        logic       sel;
        logic [3:0] outs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       idExMemRead;
    logic [2:0] idExRd;
    logic [2:0] ifIdRs1;
    logic [2:0] ifIdRs2;
    logic       ifIdUsesRs2;
    logic       branchTaken;
    logic       imemReady;

    logic        pcA, ifwA, flA, bubA;
    logic        pcB, ifwB, flB, bubB;
    logic [15:0] cntA, cntB;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   stepNum  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL(2), .BR_PENALTY(3), .REG_W(3)) dutA (
        .clk(clk), .rst(rst), .idExMemRead(idExMemRead), .idExRd(idExRd),
        .ifIdRs1(ifIdRs1), .ifIdRs2(ifIdRs2), .ifIdUsesRs2(ifIdUsesRs2),
        .branchTaken(branchTaken), .imemReady(imemReady),
        .pcWriteEn(pcA), .ifIdWriteEn(ifwA), .ifIdFlush(flA), .idExBubble(bubA),
        .stallCount(cntA)
    );

    hazard_ctrl #(.LU_STALL(4), .BR_PENALTY(1), .REG_W(3)) dutB (
        .clk(clk), .rst(rst), .idExMemRead(idExMemRead), .idExRd(idExRd),
        .ifIdRs1(ifIdRs1), .ifIdRs2(ifIdRs2), .ifIdUsesRs2(ifIdUsesRs2),
        .branchTaken(branchTaken), .imemReady(imemReady),
        .pcWriteEn(pcB), .ifIdWriteEn(ifwB), .ifIdFlush(flB), .idExBubble(bubB),
        .stallCount(cntB)
    );

    task automatic checkOutput();
        exp_t       e;
        logic [3:0] obs;
        e   = sb.pop_front();
        obs = e.sel ? {pcB, ifwB, flB, bubB} : {pcA, ifwA, flA, bubA};
        checks++;
        assert (obs === e.outs) else begin
            failures++;
            $error("[TB] FAIL step%0d dut%s outs{pc,ifw,flush,bubble} observed=%b expected=%b",
                   stepNum, e.sel ? "B" : "A", obs, e.outs);
        end
    endtask

    task automatic checkCount(input logic sel, input logic [15:0] expCount, input string tag);
        logic [15:0] obs;
        obs = sel ? cntB : cntA;
        checks++;
        assert (obs === expCount) else begin
            failures++;
            $error("[TB] FAIL %s stallCount observed=%0d expected=%0d", tag, obs, expCount);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic mr, input logic [2:0] rd,
                                 input logic [2:0] rs1, input logic [2:0] rs2, input logic u2,
                                 input logic br, input logic rdy, input logic [3:0] expOuts);
        idExMemRead = mr;
        idExRd      = rd;
        ifIdRs1     = rs1;
        ifIdRs2     = rs2;
        ifIdUsesRs2 = u2;
        branchTaken = br;
        imemReady   = rdy;
        stepNum++;
        sb.push_back('{sel: sel, outs: expOuts});
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst         = 1'b1;
        idExMemRead = 1'b0;
        idExRd      = 3'd0;
        ifIdRs1     = 3'd0;
        ifIdRs2     = 3'd0;
        ifIdUsesRs2 = 1'b0;
        branchTaken = 1'b0;
        imemReady   = 1'b1;
        stepNum++;
        sb.push_back('{sel: 1'b0, outs: RSTO});
        sb.push_back('{sel: 1'b1, outs: RSTO});
        @(negedge clk);
        checkOutput();
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        idExMemRead = 1'b0;
        idExRd      = 3'd0;
        ifIdRs1     = 3'd0;
        ifIdRs2     = 3'd0;
        ifIdUsesRs2 = 1'b0;
        branchTaken = 1'b0;
        imemReady   = 1'b1;
        @(posedge clk);
        #1;

        // Load-use on rs1 with a two-cycle stall, then pass.
        doReset();
        checkCount(1'b0, 16'd0, "afterReset");
        applyStimulus(1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, STALL);
        applyStimulus(1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, STALL);
        applyStimulus(1'b0, 1'b0, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, PASS);
        checkCount(1'b0, 16'd2, "loadUseRs1");

        // rs2 dependency only counts when the instruction reads rs2.
        doReset();
        applyStimulus(1'b0, 1'b1, 3'd5, 3'd1, 3'd5, 1'b1, 1'b0, 1'b1, STALL);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, STALL);
        applyStimulus(1'b0, 1'b1, 3'd5, 3'd1, 3'd5, 1'b0, 1'b0, 1'b1, PASS);
        checkCount(1'b0, 16'd2, "loadUseRs2");

        // Register 0 never stalls.
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, PASS);
        checkCount(1'b0, 16'd2, "regZero");

        // Branch beats a simultaneous hazard; two flush cycles follow.
        doReset();
        applyStimulus(1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1, BRNCH);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, BRFL);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, BRFL);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, PASS);
        checkCount(1'b0, 16'd0, "branchFlush");

        // Flush cycle with fetch not ready holds the PC.
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, BRNCH);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, FWAIT);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, BRFL);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, PASS);
        checkCount(1'b0, 16'd1, "flushNotReady");

        // Branch aborts a long load-use stall on the LU_STALL=4 instance.
        doReset();
        applyStimulus(1'b1, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, STALL);
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, STALL);
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, BRNCH);
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, PASS);
        checkCount(1'b1, 16'd2, "branchAbortStall");

        // Fetch wait for four cycles.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, FWAIT);
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, PASS);
        checkCount(1'b0, 16'd4, "fetchWait");

        // Reset in the second cycle of a four-cycle stall discards the count.
        doReset();
        applyStimulus(1'b1, 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 1'b1, STALL);
        doReset();
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, PASS);
        checkCount(1'b1, 16'd0, "resetMidStall");

        // Saturation after a very long fetch wait.
        doReset();
        imemReady = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        checkCount(1'b0, 16'd65534, "preSaturate");
        repeat (3) @(posedge clk);
        #1;
        checkCount(1'b0, 16'hFFFF, "saturateA");
        checkCount(1'b1, 16'hFFFF, "saturateB");
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, FWAIT);
        checkCount(1'b0, 16'hFFFF, "saturateHold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- LU_STALL, 1: load-use stall cycles, range 1..15.
- BR_PENALTY, 1: taken-branch IF/ID flush cycles, range 1..15.
- REG_W, 3: register-address width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous active-high reset.
- idExMemRead, in, 1: instruction in ID/EX is a load.
- idExRd, in, REG_W: load destination register.
- ifIdRs1, in, REG_W: IF/ID source register 1.
- ifIdRs2, in, REG_W: IF/ID source register 2.
- ifIdUsesRs2, in, 1: IF/ID instruction reads rs2.
- branchTaken, in, 1: EX resolved a taken branch this cycle.
- imemReady, in, 1: instruction memory data valid this cycle.
- pcWriteEn, out, 1: PC update enable.
- ifIdWriteEn, out, 1: IF/ID register write enable.
- ifIdFlush, out, 1: IF/ID clear to NOP.
- idExBubble, out, 1: insert NOP into ID/EX.
- stallCount, out, 16: cycles with pcWriteEn=0.

Function
REQ-003 hazard SHALL be asserted when idExMemRead=1, idExRd!=0, and (idExRd==ifIdRs1 or (ifIdUsesRs2=1 and idExRd==ifIdRs2)). Register 0 never causes a hazard.
REQ-004 The FSM SHALL have states RUN, LU_STALL, BR_FLUSH and MEM_WAIT, plus a 4-bit down-counter cnt. State and cnt SHALL be registered. Outputs SHALL be combinational from state and current inputs.
REQ-005 In any state, priority SHALL be branchTaken > hazard > !imemReady.
REQ-006 Branch action (branchTaken=1 in any state): pcWriteEn=1, ifIdWriteEn=0, ifIdFlush=1, idExBubble=1. Next state SHALL be BR_FLUSH with cnt=BR_PENALTY-1 if BR_PENALTY>1, else RUN.
REQ-007 Stall action (hazard, in RUN or LU_STALL): pcWriteEn=0, ifIdWriteEn=0, ifIdFlush=0, idExBubble=1.
- From RUN: next state LU_STALL with cnt=LU_STALL-1 if LU_STALL>1, else RUN.
REQ-008 In LU_STALL, the stall action SHALL be held regardless of the hazard input. cnt decrements each cycle; at cnt==1 the next state is RUN.
REQ-009 BR_FLUSH (no new branch): pcWriteEn=imemReady, ifIdFlush=1, ifIdWriteEn=0, idExBubble=0. cnt decrements; at cnt==1 the next state is RUN.
REQ-010 Fetch wait (RUN, no branch, no hazard, imemReady=0): pcWriteEn=0, ifIdFlush=1, ifIdWriteEn=0, idExBubble=0. Next state MEM_WAIT.
REQ-011 MEM_WAIT SHALL hold the fetch-wait outputs while imemReady=0. When imemReady=1 it SHALL apply normal pass outputs and go to RUN.
REQ-012 Normal pass (RUN, no event): pcWriteEn=1, ifIdWriteEn=1, ifIdFlush=0, idExBubble=0.
REQ-013 Invariant: ifIdFlush=1 SHALL imply ifIdWriteEn=0, and ifIdWriteEn=1 SHALL imply pcWriteEn=1.
REQ-014 stallCount SHALL increment on every clock edge where pcWriteEn=0 and rst=0, saturating at 16'hFFFF with no wrap.
REQ-015 A branch arriving during LU_STALL, BR_FLUSH or MEM_WAIT SHALL abort that state immediately per REQ-006. It SHALL reload cnt as REQ-006 specifies and SHALL NOT decrement the old count.

Reset
REQ-016 At a clock edge with rst=1, the block SHALL set state=RUN, cnt=0 and stallCount=0.
REQ-017 While rst=1, outputs SHALL be forced to pcWriteEn=0, ifIdWriteEn=0, ifIdFlush=1, idExBubble=1.
REQ-018 Reset asserted mid-stall or mid-flush SHALL discard the pending count. The first cycle after rst falls SHALL evaluate as RUN.

Structure
REQ-019 Package pipe_ctrl_pkg SHALL hold:
- the state enum;
- REG_W;
- PC width 12;
- instruction width 19;
- the NOP encoding 19'b0.
REQ-020 The combinational hazard compare of REQ-003 SHALL be a sub-module load_use_detect.
REQ-021 The implementation SHALL have no latches and a single always_ff for state, cnt and stallCount.

Verification
REQ-022 Scenario 1, load-use: LU_STALL=2, idExMemRead=1, idExRd=3, ifIdRs1=3. Required: two cycles of pcWriteEn=0, ifIdWriteEn=0, idExBubble=1, then pass outputs; stallCount=2.
REQ-023 Scenario 2, register 0: idExRd=0 and ifIdRs1=0 with idExMemRead=1. Required: no stall, pass outputs.
REQ-024 Scenario 3, branch beats hazard: BR_PENALTY=3, branchTaken=1 on the same cycle as a hazard. Required: branch action, then 2 cycles of ifIdFlush=1, then RUN; idExBubble=1 only on the first cycle.
REQ-025 Scenario 4, fetch wait: imemReady=0 for 4 cycles then 1. Required: 4 cycles of pcWriteEn=0 and ifIdFlush=1, then pass outputs; stallCount=4.
REQ-026 Scenario 5, reset mid-stall: rst=1 in the 2nd cycle of LU_STALL=4. Required: reset outputs; after release, pass outputs; stallCount=0.
REQ-027 Scenario 6, saturation: stallCount preloaded by forcing 65534 cycles of imemReady=0. Required: counter holds at 65535.
